div_unit: RTL
=============

# div_unit

Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU, sitting in the execute stage beside the ALU. It produces `div_stall`, which the hazard unit folds into its global stall (freezing F/D/E/M/W), and delivers `{HI,LO}` = `{remainder, quotient}` to the E-stage result mux. It holds the result until the divide instruction actually leaves E, and aborts on exception flush.

## Interface
- `WIDTH`, 32, operand width; iteration count = `WIDTH`.
- `clk` in 1: pipeline clock.
- `resetn` in 1: asynchronous, active-low reset.
- `div_valid` in 1: E-stage instruction is DIV/DIVU (already gated by E valid).
- `div_signed` in 1: 1 = DIV (two's complement), 0 = DIVU.
- `a` in WIDTH: dividend (forwarded rs value).
- `b` in WIDTH: divisor (forwarded rt value).
- `stallE` in 1: E stage held this cycle (hazard output).
- `cancel` in 1: exception flush (`is_exceptM`); aborts any operation.
- `div_stall` out 1: to hazard; E must hold.
- `div_ready` out 1: result valid.
- `result` out 2*WIDTH: `{remainder, quotient}`.

## Operation
- States: IDLE, BUSY, DONE.
  - IDLE: if `div_valid & ~cancel`, latch `|a|`, `|b|` (absolute values when `div_signed`), sign of quotient (`a[MSB]^b[MSB]`) and sign of remainder (`a[MSB]`), clear counter, go to BUSY.
  - BUSY: one iteration per cycle; after iteration `WIDTH-1`, apply sign correction, register `result`, go to DONE.
  - DONE: if `cancel` or `~stallE`, go to IDLE; else stay (result held).
- `cancel` in any state: next state IDLE, result is not written.
- `div_stall = div_valid & ~(state==DONE) & ~cancel` is combinational from state and inputs only. It must not depend on `stallE`, so no loop through the hazard unit.
- `div_ready = (state==DONE)`.
- Operands are sampled only at the IDLE→BUSY edge; `a`/`b` changes during BUSY (forwarding source draining) are ignored.
- Iteration datapath: `WIDTH+1`-bit partial remainder `R`, `WIDTH`-bit quotient `Q`.
  - Compute `T = {R[WIDTH-1:0], Q[MSB]} - {1'b0,|b|}`.
  - If `T` is non-negative, `R<=T` and `Q<={Q[WIDTH-2:0],1}`; else `R<={R[WIDTH-1:0],Q[MSB]}` and `Q<={Q[WIDTH-2:0],0}`.
  - Initial values: `R=0`, `Q=|a|`.
- Sign correction: negate quotient if its latched sign is 1 and `div_signed`; negate remainder if its latched sign is 1 and `div_signed`.
- Divide by zero has no special case. Magnitude quotient is all-ones and remainder is `|a|`, then sign-corrected; no stall or exception is raised.
- Signed `0x80000000 / 0xFFFFFFFF` gives quotient `0x80000000`, remainder 0 (wrap is natural).

## Timing
- Reset (async assert): state IDLE, counter 0, `result` 0, `div_ready` 0; `div_stall` follows `div_valid` combinationally.
- Cycle 0 (IDLE, `div_valid`=1): `div_stall`=1.
- Cycles 1..WIDTH (BUSY): `div_stall`=1.
- Cycle WIDTH+1 (DONE): `div_stall`=0, `div_ready`=1, `result` valid. The instruction leaves E at the end of this cycle unless another stall holds it.
- Total E occupancy is WIDTH+2 cycles (34 for 32-bit) with no other stalls.
- Back-to-back divides: the DONE→IDLE transition costs one IDLE cycle, in which the next divide starts; no result is lost.
- `cancel` with `div_valid` still high forces `div_stall`=0 in that same cycle.
- Reset mid-BUSY returns to IDLE immediately; the partial result is discarded.

## Structure
- Shared defines package holds:
  - state encodings `DIV_IDLE`/`DIV_BUSY`/`DIV_DONE`;
  - the result packing order (HI = `result[2W-1:W]`, LO = `result[W-1:0]`).
- Counter is `$clog2(WIDTH)` bits.
- One natural sub-module, `div_step`: combinational single restoring iteration taking `(R, Q, |b|)` and producing the next `(R, Q)`. It is reusable if the team later unrolls 2 bits per cycle.

## Test plan
- DIVU `a`=100, `b`=7 → after 33 stall cycles, `result` = `{0x00000002, 0x0000000E}`; `div_stall` drops in cycle 33.
- DIV `a`=-7 (`0xFFFFFFF9`), `b`=2 → quotient `0xFFFFFFFD`, remainder `0xFFFFFFFF`.
- DIV `0x80000000 / 0xFFFFFFFF` → quotient `0x80000000`, remainder 0.
- DIVU `b`=0, `a`=`0x1234` → quotient `0xFFFFFFFF`, remainder `0x1234`.
- `cancel` pulse at BUSY cycle 10 → `div_stall`=0 that cycle, IDLE next cycle, `result` unchanged.
- DONE with `stallE`=1 held 5 cycles (d_stall) → `result` stable, `div_ready`=1 throughout.
  - Then `stallE`=0 → IDLE.
  - A second divide started the following cycle completes correctly.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage radix-2 restoring divider.
// The result bus is packed as {HI, LO} = {remainder, quotient}: slot 1 of
// the 2*WIDTH result is HI, slot 0 is LO.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  localparam int DIV_LO_SLOT = 0;
  localparam int DIV_HI_SLOT = 1;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration (the div_step stage), purely
// combinational. It maps (R, Q, |b|) to the next (R, Q), so two instances
// can be chained if the divider is ever unrolled to 2 bits per cycle.
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             unused_r_msb;

  // The partial remainder is always below |b| before the shift, so its top
  // bit never carries information into the next step.
  assign unused_r_msb = r_i[WIDTH];

  assign shifted = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
  // One extra bit keeps the borrow separate even when b is zero.
  assign diff    = {1'b0, shifted} - {2'b00, b_i};

  // Keep the difference when it does not borrow, otherwise restore.
  always_comb begin
    r_o = shifted;
    q_o = {q_i[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH+1]) begin
      r_o = diff[WIDTH:0];
      q_o = {q_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle MIPS DIV/DIVU unit beside the E-stage ALU. It raises
// div_stall while it iterates, presents {remainder, quotient} in DONE, and
// holds it there until the divide leaves E. An exception flush aborts the
// operation without touching the held result.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 div_valid,
  input  logic                 div_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 stallE,
  input  logic                 cancel,
  output logic                 div_stall,
  output logic                 div_ready,
  output logic [2*WIDTH-1:0]   result
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH:0]    r_q;
  logic [WIDTH-1:0]  q_q;
  logic [WIDTH-1:0]  b_abs_q;
  logic              neg_quot_q;
  logic              neg_rem_q;
  logic [2*WIDTH-1:0] result_q;

  logic [WIDTH-1:0]  a_abs_d;
  logic [WIDTH-1:0]  b_abs_d;
  logic [WIDTH:0]    r_d;
  logic [WIDTH-1:0]  q_d;
  logic [WIDTH-1:0]  quot_d;
  logic [WIDTH-1:0]  rem_d;

  div_unit_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .b_i (b_abs_q),
    .r_o (r_d),
    .q_o (q_d)
  );

  // Operand magnitudes for the start edge, and sign-corrected final values.
  // The sign flags are latched already gated by div_signed, so DIVU never
  // negates even if div_signed moves while busy.
  always_comb begin
    a_abs_d = (div_signed && a[WIDTH-1]) ? -a : a;
    b_abs_d = (div_signed && b[WIDTH-1]) ? -b : b;
    quot_d  = neg_quot_q ? -q_d : q_d;
    rem_d   = neg_rem_q ? -r_d[WIDTH-1:0] : r_d[WIDTH-1:0];
  end

  // Sequencer and datapath registers: start in IDLE, one bit per BUSY
  // cycle, hold the result in DONE until E advances; cancel wins everywhere.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      r_q        <= '0;
      q_q        <= '0;
      b_abs_q    <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
    end else if (cancel) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (div_valid) begin
            r_q        <= '0;
            q_q        <= a_abs_d;
            b_abs_q    <= b_abs_d;
            neg_quot_q <= div_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q  <= div_signed & a[WIDTH-1];
            cnt_q      <= '0;
            state_q    <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result_q[DIV_HI_SLOT*WIDTH +: WIDTH] <= rem_d;
            result_q[DIV_LO_SLOT*WIDTH +: WIDTH] <= quot_d;
            state_q <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (!stallE) begin
            state_q <= DIV_IDLE;
          end
        end
        default: begin
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

  // stallE is deliberately absent here: the hazard unit builds stallE from
  // div_stall, so using it would close a combinational loop.
  assign div_stall = div_valid & (state_q != DIV_DONE) & ~cancel;
  assign div_ready = (state_q == DIV_DONE);
  assign result    = result_q;

endmodule
